// File: rtl/rate_controller.sv
// Three-axis PI rate controller: latches targets and gyro rates on a start pulse,
// then walks error -> gain/integrate -> sum through a one-hot FSM and pulses complete.
module rate_controller #(
  parameter logic signed [15:0] KP_MULT      = 16'sd3,
  parameter int                 KP_SHIFT     = 1,
  parameter logic signed [15:0] KI_MULT      = 16'sd1,
  parameter int                 KI_SHIFT     = 4,
  parameter int                 INT_LIMIT    = 3200,
  parameter int                 OUT_LIMIT    = 3200,
  parameter int                 THROTTLE_MAX = 4000
) (
  input  logic               us_clk,
  input  logic               resetn,
  input  logic               start_signal,
  input  logic signed [15:0] throttle_rate_in,
  input  logic signed [15:0] yaw_rate_in,
  input  logic signed [15:0] pitch_rate_in,
  input  logic signed [15:0] roll_rate_in,
  input  logic signed [15:0] yaw_rate_actual,
  input  logic signed [15:0] pitch_rate_actual,
  input  logic signed [15:0] roll_rate_actual,
  input  logic               integrator_clear,
  output logic signed [15:0] throttle_val_out,
  output logic signed [15:0] yaw_val_out,
  output logic signed [15:0] pitch_val_out,
  output logic signed [15:0] roll_val_out,
  output logic               active_signal,
  output logic               complete_signal
);

  localparam logic signed [31:0] KP_W   = 32'(KP_MULT);
  localparam logic signed [31:0] KI_W   = 32'(KI_MULT);
  localparam logic signed [31:0] INT_HI = INT_LIMIT;
  localparam logic signed [31:0] INT_LO = -INT_LIMIT;
  localparam logic signed [31:0] OUT_HI = OUT_LIMIT;
  localparam logic signed [31:0] OUT_LO = -OUT_LIMIT;
  localparam logic signed [31:0] THR_HI = THROTTLE_MAX;

  typedef enum logic [5:0] {
    WAITING  = 6'b000001,
    LATCH    = 6'b000010,
    ERROR    = 6'b000100,
    SCALE    = 6'b001000,
    SUM      = 6'b010000,
    COMPLETE = 6'b100000
  } state_t;

  function automatic logic signed [15:0] clamp16(input logic signed [31:0] x,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    if (x < lo)      return lo[15:0];
    else if (x > hi) return hi[15:0];
    else             return x[15:0];
  endfunction

  function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
    return clamp16(x, -32'sd32768, 32'sd32767);
  endfunction

  state_t             state_q;
  logic signed [15:0] thr_q, thr_out_q;
  // Axis index: 0 = yaw, 1 = pitch, 2 = roll
  logic signed [15:0] tgt_q [3];
  logic signed [15:0] act_q [3];
  logic signed [15:0] err_q [3];
  logic signed [15:0] p_q   [3];
  logic signed [15:0] iacc_q[3];
  logic signed [15:0] out_q [3];

  logic signed [15:0] err_d [3];
  logic signed [15:0] p_d   [3];
  logic signed [15:0] iacc_d[3];
  logic signed [15:0] out_d [3];
  logic signed [16:0] diff  [3];
  logic signed [16:0] osum  [3];
  logic signed [31:0] kp_prod[3];
  logic signed [31:0] ki_term[3];
  logic signed [31:0] isum  [3];
  logic signed [15:0] thr_sat;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      diff[k]    = {tgt_q[k][15], tgt_q[k]} - {act_q[k][15], act_q[k]};
      err_d[k]   = sat16(32'(diff[k]));
      kp_prod[k] = 32'(err_q[k]) * KP_W;
      p_d[k]     = sat16(kp_prod[k] >>> KP_SHIFT);
      ki_term[k] = (32'(err_q[k]) * KI_W) >>> KI_SHIFT;
      isum[k]    = 32'(iacc_q[k]) + ki_term[k];
      iacc_d[k]  = clamp16(isum[k], INT_LO, INT_HI);
      osum[k]    = {p_q[k][15], p_q[k]} + {iacc_q[k][15], iacc_q[k]};
      out_d[k]   = clamp16(32'(osum[k]), OUT_LO, OUT_HI);
    end
    thr_sat = clamp16(32'(thr_q), 32'sd0, THR_HI);
  end

  always_ff @(posedge us_clk) begin
    if (!resetn) begin
      state_q   <= WAITING;
      thr_q     <= '0;
      thr_out_q <= '0;
      for (int k = 0; k < 3; k++) begin
        tgt_q[k]  <= '0;
        act_q[k]  <= '0;
        err_q[k]  <= '0;
        p_q[k]    <= '0;
        iacc_q[k] <= '0;
        out_q[k]  <= '0;
      end
    end else begin
      unique case (state_q)
        WAITING: if (start_signal) state_q <= LATCH;
        LATCH: begin
          thr_q    <= throttle_rate_in;
          tgt_q[0] <= yaw_rate_in;
          tgt_q[1] <= pitch_rate_in;
          tgt_q[2] <= roll_rate_in;
          act_q[0] <= yaw_rate_actual;
          act_q[1] <= pitch_rate_actual;
          act_q[2] <= roll_rate_actual;
          state_q  <= ERROR;
        end
        ERROR: begin
          for (int k = 0; k < 3; k++) err_q[k] <= err_d[k];
          state_q <= SCALE;
        end
        SCALE: begin
          // Integrators are held at zero while the craft has no positive throttle
          for (int k = 0; k < 3; k++) begin
            p_q[k]    <= p_d[k];
            iacc_q[k] <= (thr_q <= 16'sd0) ? 16'sd0 : iacc_d[k];
          end
          state_q <= SUM;
        end
        SUM: begin
          for (int k = 0; k < 3; k++) out_q[k] <= out_d[k];
          thr_out_q <= thr_sat;
          state_q   <= COMPLETE;
        end
        COMPLETE: state_q <= WAITING;
        default:  state_q <= WAITING;
      endcase
      // Placed after the case so the clear overrides a same-edge SCALE update
      if (integrator_clear) begin
        for (int k = 0; k < 3; k++) iacc_q[k] <= '0;
      end
    end
  end

  assign throttle_val_out = thr_out_q;
  assign yaw_val_out      = out_q[0];
  assign pitch_val_out    = out_q[1];
  assign roll_val_out     = out_q[2];
  assign active_signal    = state_q inside {LATCH, ERROR, SCALE, SUM};
  assign complete_signal  = (state_q == COMPLETE);

endmodule

// File: tb/tb_rate_controller.sv
// Directed bench for rate_controller: reset, PI arithmetic, clamps, integrator clear,
// mid-computation reset and start-ignore behaviour.
module tb_rate_controller;

  logic               us_clk = 1'b0;
  logic               resetn;
  logic               start_signal;
  logic signed [15:0] throttle_rate_in;
  logic signed [15:0] yaw_rate_in, pitch_rate_in, roll_rate_in;
  logic signed [15:0] yaw_rate_actual, pitch_rate_actual, roll_rate_actual;
  logic               integrator_clear;
  logic signed [15:0] throttle_val_out, yaw_val_out, pitch_val_out, roll_val_out;
  logic               active_signal, complete_signal;

  int total = 0;
  int bad   = 0;

  always #5 us_clk = ~us_clk;

  rate_controller dut (
    .us_clk           (us_clk),
    .resetn           (resetn),
    .start_signal     (start_signal),
    .throttle_rate_in (throttle_rate_in),
    .yaw_rate_in      (yaw_rate_in),
    .pitch_rate_in    (pitch_rate_in),
    .roll_rate_in     (roll_rate_in),
    .yaw_rate_actual  (yaw_rate_actual),
    .pitch_rate_actual(pitch_rate_actual),
    .roll_rate_actual (roll_rate_actual),
    .integrator_clear (integrator_clear),
    .throttle_val_out (throttle_val_out),
    .yaw_val_out      (yaw_val_out),
    .pitch_val_out    (pitch_val_out),
    .roll_val_out     (roll_val_out),
    .active_signal    (active_signal),
    .complete_signal  (complete_signal)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge us_clk);
    #1;
  endtask

  // Runs one computation; clr_cyc selects the edge after the start edge on which
  // integrator_clear is high (0 = never). Ends with the FSM back in WAITING.
  task automatic do_comp(input logic signed [15:0] thr,
                         input logic signed [15:0] yt, input logic signed [15:0] ya,
                         input logic signed [15:0] pt, input logic signed [15:0] pa,
                         input logic signed [15:0] rt, input logic signed [15:0] ra,
                         input int clr_cyc, output logic act1);
    int lat;
    throttle_rate_in  = thr;
    yaw_rate_in       = yt;
    yaw_rate_actual   = ya;
    pitch_rate_in     = pt;
    pitch_rate_actual = pa;
    roll_rate_in      = rt;
    roll_rate_actual  = ra;
    start_signal      = 1'b1;
    step();
    start_signal = 1'b0;
    act1 = active_signal;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      integrator_clear = (n == clr_cyc);
      step();
      integrator_clear = 1'b0;
      if (complete_signal) begin
        lat = n;
        break;
      end
    end
    chk("latency", lat, 4);
    step();
    chk("pulse_end", {31'd0, complete_signal}, 0);
  endtask

  initial begin
    logic act1;
    int   cnt;

    resetn            = 1'b0;
    start_signal      = 1'b0;
    integrator_clear  = 1'b0;
    throttle_rate_in  = '0;
    yaw_rate_in       = '0;
    pitch_rate_in     = '0;
    roll_rate_in      = '0;
    yaw_rate_actual   = '0;
    pitch_rate_actual = '0;
    roll_rate_actual  = '0;

    // Reset held for two edges
    step();
    step();
    chk("rst_thr", throttle_val_out, 0);
    chk("rst_yaw", yaw_val_out, 0);
    chk("rst_pitch", pitch_val_out, 0);
    chk("rst_roll", roll_val_out, 0);
    chk("rst_active", {31'd0, active_signal}, 0);
    chk("rst_complete", {31'd0, complete_signal}, 0);

    // Start sampled on the first edge with reset released; pitch 160 -> p 240 + i 10
    resetn = 1'b1;
    do_comp(16'sd800, 0, 0, 16'sd160, 0, 0, 0, 0, act1);
    chk("active_after_start", {31'd0, act1}, 1);
    chk("basic_pitch", pitch_val_out, 250);
    chk("basic_thr", throttle_val_out, 800);
    chk("basic_yaw", yaw_val_out, 0);
    chk("basic_roll", roll_val_out, 0);
    chk("hold_active", {31'd0, active_signal}, 0);
    step();
    step();
    chk("hold_pitch", pitch_val_out, 250);

    // Zero throttle: integrators forced to 0, output is p alone
    for (int i = 0; i < 5; i++) begin
      do_comp(16'sd0, 0, 16'sd64, 16'sd160, 0, 0, 0, 0, act1);
      chk("thr0_pitch", pitch_val_out, 240);
      chk("thr0_yaw", yaw_val_out, -96);
      chk("thr0_thr", throttle_val_out, 0);
    end
    do_comp(-16'sd16, 0, 0, 0, 0, 0, 0, 0, act1);
    chk("thr_neg", throttle_val_out, 0);
    chk("thr_neg_pitch", pitch_val_out, 0);
    do_comp(16'sd5000, 0, 0, 0, 0, 0, 0, 0, act1);
    chk("thr_max", throttle_val_out, 4000);
    chk("thr_max_pitch", pitch_val_out, 0);

    // Roll error saturation and integrator upper clamp
    for (int i = 0; i < 30; i++) begin
      do_comp(16'sd800, 0, 0, 0, 0, 16'sd32767, -16'sd32768, 0, act1);
      chk("roll_sat", roll_val_out, 3200);
    end
    chk("roll_sat_pitch", pitch_val_out, 0);
    do_comp(16'sd800, 0, 0, 0, 0, -16'sd160, 0, 0, act1);
    chk("roll_int_top", roll_val_out, 2950);

    // Negative saturation and integrator lower clamp
    for (int i = 0; i < 4; i++) begin
      do_comp(16'sd800, 0, 0, 0, 0, -16'sd32768, 16'sd32767, 0, act1);
      chk("roll_neg_sat", roll_val_out, -3200);
    end
    do_comp(16'sd800, 0, 0, 0, 0, 0, 0, 0, act1);
    chk("roll_int_low", roll_val_out, -3200);
    do_comp(16'sd800, 0, 0, 0, 0, 16'sd160, 0, 0, act1);
    chk("roll_int_low_up", roll_val_out, -2950);

    // Clear while idle, then build pitch integrator to 100 and clear during SCALE
    integrator_clear = 1'b1;
    step();
    integrator_clear = 1'b0;
    do_comp(16'sd800, 0, 0, 0, 0, 0, 0, 0, act1);
    chk("idle_clear_roll", roll_val_out, 0);
    for (int i = 0; i < 10; i++) do_comp(16'sd800, 0, 0, 16'sd160, 0, 0, 0, 0, act1);
    chk("pitch_i100", pitch_val_out, 340);
    do_comp(16'sd800, 0, 0, 16'sd160, 0, 0, 0, 3, act1);
    chk("clear_in_scale", pitch_val_out, 240);
    do_comp(16'sd800, 0, 0, 16'sd160, 0, 0, 0, 0, act1);
    chk("after_clear", pitch_val_out, 250);

    // Reset while in SCALE abandons the computation
    throttle_rate_in  = 16'sd800;
    pitch_rate_in     = 16'sd160;
    pitch_rate_actual = 16'sd0;
    roll_rate_in      = 16'sd0;
    start_signal      = 1'b1;
    step();
    start_signal = 1'b0;
    step();
    step();
    resetn = 1'b0;
    step();
    chk("midrst_pitch", pitch_val_out, 0);
    chk("midrst_thr", throttle_val_out, 0);
    chk("midrst_active", {31'd0, active_signal}, 0);
    chk("midrst_complete", {31'd0, complete_signal}, 0);
    resetn = 1'b1;
    pitch_rate_in = 16'sd0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (complete_signal) cnt++;
    end
    chk("midrst_no_pulse", cnt, 0);
    do_comp(16'sd800, 0, 0, 0, 0, 0, 0, 0, act1);
    chk("midrst_int_zero", pitch_val_out, 0);

    // Second start while in ERROR is ignored: exactly one pulse
    throttle_rate_in = 16'sd800;
    pitch_rate_in    = 16'sd160;
    start_signal     = 1'b1;
    step();
    start_signal = 1'b0;
    step();
    start_signal = 1'b1;
    step();
    start_signal = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (complete_signal) cnt++;
    end
    chk("err_start_pulses", cnt, 1);
    chk("err_start_pitch", pitch_val_out, 250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rate_controller.md
RATE_CONTROLLER -- requirements
Module: rate_controller

Interface
REQ-001 Parameter KP_MULT, default 3: proportional gain numerator, signed 16-bit.
REQ-002 Parameter KP_SHIFT, default 1: proportional gain right-shift (gain = KP_MULT / 2^KP_SHIFT).
REQ-003 Parameter KI_MULT, default 1: integral gain numerator, signed 16-bit.
REQ-004 Parameter KI_SHIFT, default 4: integral gain right-shift.
REQ-005 Parameter INT_LIMIT, default 3200 (200.0 deg/s in 12.4): per-axis integrator magnitude clamp.
REQ-006 Parameter OUT_LIMIT, default 3200: per-axis output magnitude clamp.
REQ-007 Parameter THROTTLE_MAX, default 4000: throttle output upper clamp.
REQ-008 us_clk  in  1  sole clock; all logic on its rising edge.
REQ-009 resetn  in  1  reset, synchronous, active-low.
REQ-010 start_signal  in  1  start request; driven by the upstream angle stage's complete pulse.
REQ-011 throttle_rate_in  in  16  signed 12.4 throttle target.
REQ-012 yaw_rate_in, pitch_rate_in, roll_rate_in  in  16 each  signed 12.4 target rates, deg/s.
REQ-013 yaw_rate_actual, pitch_rate_actual, roll_rate_actual  in  16 each  signed 12.4 gyro rates, deg/s.
REQ-014 integrator_clear  in  1  synchronous clear of all three integrators.
REQ-015 throttle_val_out, yaw_val_out, pitch_val_out, roll_val_out  out  16 each  signed 12.4 registered results.
REQ-016 active_signal  out  1  high while a computation is in progress.
REQ-017 complete_signal  out  1  one-cycle pulse; outputs valid and new.

Function
REQ-018 The FSM SHALL be one-hot with states WAITING, LATCH, ERROR, SCALE, SUM, COMPLETE, advancing one state per edge in that order, COMPLETE -> WAITING unconditionally.
REQ-019 WAITING SHALL move to LATCH on any edge where start_signal = 1; a one-cycle pulse SHALL suffice; start_signal outside WAITING SHALL be ignored (no queueing).
REQ-020 If start_signal is high on the edge leaving COMPLETE it SHALL be ignored; if still high in WAITING, a new computation SHALL begin.
REQ-021 LATCH SHALL capture all seven rate inputs; inputs SHALL NOT affect a computation after LATCH.
REQ-022 ERROR SHALL compute err = target - actual per axis in 17 bits, saturated to [-32768, 32767].
REQ-023 SCALE SHALL compute p = (err * KP_MULT) >>> KP_SHIFT in 32-bit signed, saturated to 16 bits.
REQ-024 SCALE SHALL update i_acc = clamp(i_acc + ((err * KI_MULT) >>> KI_SHIFT), -INT_LIMIT, +INT_LIMIT), summed in 32 bits before the clamp.
REQ-025 SUM SHALL register axis output = clamp(p + i_acc, -OUT_LIMIT, +OUT_LIMIT) using a 17-bit sum, and throttle_val_out = clamp(latched throttle, 0, THROTTLE_MAX).
REQ-026 active_signal SHALL equal (state in LATCH, ERROR, SCALE, SUM); complete_signal SHALL equal (state == COMPLETE); both decoded from the state register only.
REQ-027 Latency: start sampled at edge N -> outputs updated and complete_signal high in the cycle following edge N+4, for exactly one cycle.
REQ-028 Outputs SHALL hold their values between computations.
REQ-029 Integrators SHALL persist across computations.
REQ-030 Integrators SHALL be forced to 0 in SCALE when the latched throttle <= 0.
REQ-031 integrator_clear = 1 SHALL zero all integrators on that edge, taking priority over a SCALE update; the computation SHALL otherwise proceed.

Reset
REQ-032 resetn = 0 at an edge SHALL set state = WAITING and set all outputs, active_signal, complete_signal, latched inputs, err, p and integrators to 0.
REQ-033 Reset mid-computation SHALL abandon it with no complete pulse.
REQ-034 After reset, start_signal SHALL be sampled on the first edge with resetn = 1.

Verification
REQ-035 Hold resetn = 0 for 2 cycles -> all outputs 0, active = 0, complete = 0; state WAITING.
REQ-036 Pitch target 160, actual 0, throttle 800, 1-cycle start -> complete 5 cycles after start sample; pitch_val_out = 250 (p 240 + i 10); throttle_val_out = 800; yaw and roll outputs 0.
REQ-037 Roll target 32767, actual -32768 -> err saturates to 32767, p saturates to 32767, roll_val_out = 3200; 30 back-to-back cycles -> integrator stops at 3200, never exceeds it.
REQ-038 Throttle 0 with pitch err 160 over 5 cycles -> integrators stay 0, pitch_val_out = 240; throttle -16 -> throttle_val_out = 0; throttle 5000 -> throttle_val_out = 4000.
REQ-039 Assert integrator_clear in SCALE after integrator reached 100 -> integrator = 0, output equals p alone.
REQ-040 resetn = 0 during SCALE -> no complete pulse, outputs 0; start during ERROR -> ignored, exactly one complete pulse.
